// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit: one-hot mode,
// FSM states and the effective shift-count helper.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_NONE  = 3'b001,
        MODE_RIGHT = 3'b010,
        MODE_LEFT  = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Rotation wraps the count modulo WIDTH; zero fill saturates at WIDTH.
    function automatic int unsigned eff_count(
        input int unsigned amt,
        input int unsigned width,
        input logic        rot
    );
        if (rot) return amt & (width - 1);
        return (amt > width) ? width : amt;
    endfunction

endpackage

// File: rtl/shift_mode_decode.sv
// Priority decode of the raw shift request lines into a one-hot mode.
// Contradictory or empty requests fall back to pass-through with err set.
module shift_mode_decode
    import shift_pkg::*;
(
    input  logic  left_i,
    input  logic  right_i,
    input  logic  no_shift_n_i,
    output mode_e mode_o,
    output logic  err_o
);

    // Pass-through request wins, then exactly-one-of left/right.
    always_comb begin
        mode_o = MODE_NONE;
        err_o  = 1'b0;
        if (!no_shift_n_i) begin
            mode_o = MODE_NONE;
        end else if (left_i && !right_i) begin
            mode_o = MODE_LEFT;
        end else if (right_i && !left_i) begin
            mode_o = MODE_RIGHT;
        end else begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: one bit position per clock, dual-rail result.
// Optional macro SHIFT_UNIT_ROTATE_EN adds a rotate input.
module shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Ax,
    input  logic             left,
    input  logic             right,
    input  logic             no_shift_n,
    input  logic [AMT_W-1:0] amount,
`ifdef SHIFT_UNIT_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_n,
    output logic             leftx,
    output logic             rightx,
    output logic             no_shiftx
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             rot_q, rot_d;

    mode_e            dec_mode;
    logic             dec_err;
    logic             rot_in;
    logic [AMT_W-1:0] acc_cnt;
    logic [WIDTH-1:0] shl, shr;

`ifdef SHIFT_UNIT_ROTATE_EN
    assign rot_in = rotate;
`else
    assign rot_in = 1'b0;
`endif

    shift_mode_decode u_dec (
        .left_i       (left),
        .right_i      (right),
        .no_shift_n_i (no_shift_n),
        .mode_o       (dec_mode),
        .err_o        (dec_err)
    );

    assign acc_cnt = (dec_mode == MODE_NONE) ? '0 :
        AMT_W'(eff_count(32'(amount), WIDTH, rot_in));

    assign shl = {res_q[WIDTH-2:0], rot_q & res_q[WIDTH-1]};
    assign shr = {rot_q & res_q[0], res_q[WIDTH-1:1]};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NONE;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rot_q   <= rot_d;
        end
    end

    // Accept in IDLE, one shift per cycle in SHIFT, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rot_d   = rot_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    res_d   = Ax;
                    mode_d  = dec_mode;
                    err_d   = dec_err;
                    rot_d   = rot_in;
                    cnt_d   = acc_cnt;
                    state_d = (acc_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (mode_q == MODE_LEFT) begin
                    res_d = shl;
                end else if (mode_q == MODE_RIGHT) begin
                    res_d = shr;
                end
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign result    = res_q;
    assign result_n  = ~res_q;
    assign leftx     = (mode_q == MODE_LEFT);
    assign rightx    = (mode_q == MODE_RIGHT);
    assign no_shiftx = (mode_q == MODE_NONE);

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit (WIDTH=8, AMT_W=4).
// Build with SHIFT_UNIT_ROTATE_EN defined to also cover rotation.
module tb_shift_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] Ax;
    logic       left;
    logic       right;
    logic       no_shift_n;
    logic [3:0] amount;
`ifdef SHIFT_UNIT_ROTATE_EN
    logic       rotate;
`endif
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic [7:0] result_n;
    logic       leftx;
    logic       rightx;
    logic       no_shiftx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Ax         (Ax),
        .left       (left),
        .right      (right),
        .no_shift_n (no_shift_n),
        .amount     (amount),
`ifdef SHIFT_UNIT_ROTATE_EN
        .rotate     (rotate),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .result_n   (result_n),
        .leftx      (leftx),
        .rightx     (rightx),
        .no_shiftx  (no_shiftx)
    );

    // Drive one operation; cyc returns the cycle done was seen (-1 on timeout).
    task automatic do_op(
        input  logic [7:0] a,
        input  logic       l,
        input  logic       r,
        input  logic       nsn,
        input  logic [3:0] amt,
        input  logic       rot,
        output int         cyc
    );
        @(posedge clk);
        #1;
        Ax = a; left = l; right = r; no_shift_n = nsn; amount = amt;
`ifdef SHIFT_UNIT_ROTATE_EN
        rotate = rot;
`else
        if (rot) $display("note: rotate ignored in this build");
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                cyc = n;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; Ax = '0; left = 1'b0;
        right = 1'b0; no_shift_n = 1'b1; amount = '0;
`ifdef SHIFT_UNIT_ROTATE_EN
        rotate = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {busy, done, err});
        end
        total++;
        if (result !== 8'h00 || result_n !== 8'hFF) begin
            bad++;
            $display("FAIL reset_result got=%h/%h want=00/ff", result, result_n);
        end
        total++;
        if ({leftx, rightx, no_shiftx} !== 3'b001) begin
            bad++;
            $display("FAIL reset_mode got=%b want=001", {leftx, rightx, no_shiftx});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_left;
        int cyc;
        do_op(8'hB5, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, cyc);
        total++;
        if (cyc !== 4) begin
            bad++;
            $display("FAIL left_latency got=%0d want=4", cyc);
        end
        total++;
        if (result !== 8'hA8 || result_n !== 8'h57) begin
            bad++;
            $display("FAIL left_result got=%h/%h want=a8/57", result, result_n);
        end
        total++;
        if ({leftx, rightx, no_shiftx, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL left_mode got=%b want=1000", {leftx, rightx, no_shiftx, busy});
        end
    endtask

    task automatic test_right;
        int cyc;
        do_op(8'hB5, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, cyc);
        total++;
        if (cyc !== 3) begin
            bad++;
            $display("FAIL right_latency got=%0d want=3", cyc);
        end
        total++;
        if (result !== 8'h2D || {leftx, rightx, no_shiftx} !== 3'b010) begin
            bad++;
            $display("FAIL right_result got=%h/%b want=2d/010", result, {leftx, rightx, no_shiftx});
        end
    endtask

    task automatic test_none;
        int cyc;
        do_op(8'h3C, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, cyc);
        total++;
        if (cyc !== 1) begin
            bad++;
            $display("FAIL none_latency got=%0d want=1", cyc);
        end
        total++;
        if (result !== 8'h3C || {leftx, rightx, no_shiftx, err} !== 4'b0010) begin
            bad++;
            $display("FAIL none_result got=%h/%b want=3c/0010", result, {leftx, rightx, no_shiftx, err});
        end
    endtask

    task automatic test_illegal;
        int cyc;
        do_op(8'h0F, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, cyc);
        total++;
        if (cyc !== 1 || result !== 8'h0F || err !== 1'b1 || no_shiftx !== 1'b1) begin
            bad++;
            $display("FAIL illegal_both got=%0d/%h/%b/%b want=1/0f/1/1", cyc, result, err, no_shiftx);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b want=1", err);
        end
        do_op(8'h01, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, cyc);
        total++;
        if (err !== 1'b0 || result !== 8'h02 || cyc !== 2) begin
            bad++;
            $display("FAIL err_clear got=%b/%h/%0d want=0/02/2", err, result, cyc);
        end
        do_op(8'h55, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, cyc);
        total++;
        if (err !== 1'b1 || result !== 8'h55 || cyc !== 1) begin
            bad++;
            $display("FAIL illegal_neither got=%b/%h/%0d want=1/55/1", err, result, cyc);
        end
    endtask

    task automatic test_saturate;
        int cyc;
        do_op(8'hFF, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0, cyc);
        total++;
        if (cyc !== 9 || result !== 8'h00) begin
            bad++;
            $display("FAIL saturate_left got=%0d/%h want=9/00", cyc, result);
        end
        do_op(8'hFF, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0, cyc);
        total++;
        if (cyc !== 9 || result !== 8'h00) begin
            bad++;
            $display("FAIL saturate_right got=%0d/%h want=9/00", cyc, result);
        end
    endtask

`ifdef SHIFT_UNIT_ROTATE_EN
    task automatic test_rotate;
        int cyc;
        do_op(8'h81, 1'b1, 1'b0, 1'b1, 4'd12, 1'b1, cyc);
        total++;
        if (cyc !== 5 || result !== 8'h18) begin
            bad++;
            $display("FAIL rotate_left got=%0d/%h want=5/18", cyc, result);
        end
        do_op(8'h03, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, cyc);
        total++;
        if (cyc !== 2 || result !== 8'h81) begin
            bad++;
            $display("FAIL rotate_right got=%0d/%h want=2/81", cyc, result);
        end
        do_op(8'hC3, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1, cyc);
        total++;
        if (cyc !== 1 || result !== 8'hC3) begin
            bad++;
            $display("FAIL rotate_full got=%0d/%h want=1/c3", cyc, result);
        end
    endtask
`endif

    // Ignored start while busy, late input changes, and hold after done.
    task automatic test_busy_hold;
        int cyc;
        cyc = -1;
        @(posedge clk);
        #1;
        Ax = 8'h80; left = 1'b0; right = 1'b1; no_shift_n = 1'b1; amount = 4'd6;
`ifdef SHIFT_UNIT_ROTATE_EN
        rotate = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        Ax = 8'hFF; left = 1'b1; right = 1'b0; amount = 4'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 3; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                cyc = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (cyc !== 7 || result !== 8'h02 || rightx !== 1'b1) begin
            bad++;
            $display("FAIL busy_ignore got=%0d/%h/%b want=7/02/1", cyc, result, rightx);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (result !== 8'h02 || {leftx, rightx, no_shiftx, busy, done} !== 5'b01000) begin
            bad++;
            $display("FAIL hold_after got=%h/%b want=02/01000", result, {leftx, rightx, no_shiftx, busy, done});
        end
    endtask

    task automatic test_reset_mid;
        logic saw_done;
        saw_done = 1'b0;
        @(posedge clk);
        #1;
        Ax = 8'hF0; left = 1'b0; right = 1'b1; no_shift_n = 1'b1; amount = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy got=%b want=1", busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, err} !== 3'b000 || result !== 8'h00 ||
            result_n !== 8'hFF || {leftx, rightx, no_shiftx} !== 3'b001) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h/%b want=000/00/001",
                     {busy, done, err}, result, {leftx, rightx, no_shiftx});
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_done got=%b want=0", saw_done);
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_right();
        test_none();
        test_illegal();
        test_saturate();
`ifdef SHIFT_UNIT_ROTATE_EN
        test_rotate();
`endif
        test_busy_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
